beeper_arbiter: RTL and testbench
=================================

# beeper_arbiter

Shares the single `Beeper` tone generator between three requesters: alarm (highest priority), key click, and UART song playback (lowest). The block grants one requester at a time. It latches that requester's tone and duration and drives `tone`/`tone_en` into `Beeper` for the requested number of milliseconds. It then enforces a silent gap before the next grant. It sits between the song controller, key scanner and alarm logic on one side and the `Beeper` instance on the other.

## Interface
- `TICK_DIV`, default 12000: clk cycles per 1 ms tick (12 MHz clock).
- `GAP_MS`, default 20: silent ms inserted after every grant ends. 0 is legal and means no gap.
- `clk` in 1: system clock, 12 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 3: request lines. Bit 2 is alarm, bit 1 is key click, bit 0 is song. A requester holds its bit high until it sees `done` or `abort`.
- `tone0`, `tone1`, `tone2` in 5 each: note code per requester, sampled at grant.
- `dur0`, `dur1`, `dur2` in 12 each: duration in ms per requester, sampled at grant.
- `grant` out 3: one-hot grant (or zero), registered.
- `done` out 3: 1-cycle pulse to the granted requester when its duration expires.
- `abort` out 3: 1-cycle pulse when a grant ends early.
- `tone` out 5: note code to `Beeper`.
- `tone_en` out 1: enable to `Beeper`.
- `busy` out 1: high in PLAY or GAP.

## Operation
- FSM states: IDLE, PLAY, GAP. Reset enters IDLE.
- Reset values: all outputs 0. `tone_en` is 0 and `tone` is 5'd0.
- IDLE, any `req` bit set:
  - Pick the highest set index.
  - Set that `grant` bit.
  - Latch its tone into `tone` and its duration into the ms down-counter `rem` (12 bit).
  - Clear the tick prescaler.
  - Go to PLAY.
- IDLE, `dur` = 0 at grant:
  - No PLAY cycle. `tone_en` stays 0.
  - `done` pulses with `grant` in the same cycle.
  - `grant` clears next cycle. Go to GAP.
- PLAY behaviour:
  - `tone_en` = 1.
  - The prescaler counts 0..TICK_DIV-1. At terminal count, `rem` decrements.
  - When `rem` reaches 0, pulse `done` for the granted bit, clear `grant` and `tone_en`, and go to GAP.
- PLAY, granted requester drops `req`: `abort` pulses for that bit, `grant` and `tone_en` clear, go to GAP. `done` does not pulse.
- GAP: count GAP_MS ticks with `tone_en` = 0, then go to IDLE. With GAP_MS = 0, go straight to IDLE on the next cycle.
- Requests arriving during PLAY or GAP wait. They are arbitrated freshly in IDLE; there is no queue and no fairness beyond fixed priority.
- Width rules: `rem` is 12 bit, so the maximum duration is 4095 ms. The prescaler is $clog2(TICK_DIV) bits. The gap counter is wide enough for GAP_MS.

## Timing
- `req` rising in IDLE to `grant` and `tone_en` high: 1 clk (registered).
- Duration: `tone_en` stays high for exactly `dur`×TICK_DIV clk cycles.
- `done` and `abort` are asserted in the same cycle that `grant` falls.
- Gap: `grant` is 0 for GAP_MS×TICK_DIV + 1 cycles before the next grant can rise. The +1 is the IDLE arbitration cycle.
- A requester that deasserts `req` on the same cycle its `done` fires receives `done`, not `abort`.
- Simultaneous requests are resolved in a single cycle by fixed priority 2 > 1 > 0.
- `rst_n` asserted mid-PLAY: all outputs go to 0 immediately (asynchronously). No `done` or `abort` pulse is issued.

## Configuration
- Macro: `BEEPER_ARB_PREEMPT_EN`.
- Defined: in PLAY, a higher-index `req` preempts the current grant.
  - `abort` pulses for the current requester.
  - In the same cycle, `grant` moves to the new requester, with its tone and duration latched and the prescaler cleared.
  - No GAP is inserted, and `tone_en` stays high.
  - Preemption is not allowed during GAP; the new request waits for IDLE.
- Undefined: non-preemptive. Higher requests wait for GAP to end.

## Test plan
All scenarios use TICK_DIV=10, GAP_MS=2.
- Single grant: `req`=3'b001, `dur0`=5, `tone0`=7 → `grant`=001 and `tone`=7 one cycle later; `tone_en` high for 50 cycles; `done[0]` pulse; `grant`=0 for 21 cycles.
- Contention: `req`=3'b111 in one cycle → `grant`=100 first. After `done[2]` and the gap, with `req`=011, the next grant is 010.
- Zero duration: `dur1`=0, `req[1]` → `done[1]` with `grant`=010 in the same cycle; `tone_en` never rises; GAP is still executed.
- Withdraw: `req[0]` dropped 13 cycles into PLAY → `abort[0]` pulse, no `done[0]`, `tone_en` low the next cycle.
- Reset mid-PLAY: `rst_n` low at cycle 20 of a 50-cycle grant → `grant`, `tone_en`, `tone` and `busy` are 0 while `rst_n` is low. After release, the block returns to IDLE.
- With `BEEPER_ARB_PREEMPT_EN`: song playing, `req[2]` rises → `abort[0]`, `grant`=100 in the same cycle, and `tone_en` shows no low cycle.

Source files
------------

// File: rtl/beeper_arbiter.sv
// Fixed-priority arbiter sharing one Beeper between alarm, key click and song.
// Optional preemption of a playing grant by a higher requester: BEEPER_ARB_PREEMPT_EN.
module beeper_arbiter #(
    parameter int unsigned TICK_DIV = 12000,
    parameter int unsigned GAP_MS   = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [4:0]  tone0,
    input  logic [4:0]  tone1,
    input  logic [4:0]  tone2,
    input  logic [11:0] dur0,
    input  logic [11:0] dur1,
    input  logic [11:0] dur2,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic [2:0]  abort,
    output logic [4:0]  tone,
    output logic        tone_en,
    output logic        busy
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GW = (GAP_MS > 1) ? $clog2(GAP_MS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_MS > 0) ? GAP_MS - 1 : 0);

`ifdef BEEPER_ARB_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t         state;
    logic [11:0]    rem;
    logic [PW-1:0]  pre;
    logic [GW-1:0]  gap_cnt;

    logic [2:0]     req_hot;
    logic [4:0]     sel_tone;
    logic [11:0]    sel_dur;
    logic [2:0]     above;
    logic           tick;
    logic           cur_req;

    // Highest-priority request and its tone/duration; request bits above the current grant
    always_comb begin
        req_hot  = 3'b000;
        sel_tone = tone0;
        sel_dur  = dur0;
        if (req[2]) begin
            req_hot  = 3'b100;
            sel_tone = tone2;
            sel_dur  = dur2;
        end else if (req[1]) begin
            req_hot  = 3'b010;
            sel_tone = tone1;
            sel_dur  = dur1;
        end else if (req[0]) begin
            req_hot  = 3'b001;
        end
        above   = ~(3'(grant << 1) - 3'd1);
        tick    = (pre == PRE_LAST);
        cur_req = |(req & grant);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= '0;
            done    <= '0;
            abort   <= '0;
            tone    <= '0;
            tone_en <= 1'b0;
            rem     <= '0;
            pre     <= '0;
            gap_cnt <= '0;
        end else begin
            done  <= '0;
            abort <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant   <= req_hot;
                        tone    <= sel_tone;
                        rem     <= sel_dur;
                        pre     <= '0;
                        gap_cnt <= '0;
                        if (sel_dur == 12'd0) begin
                            // Zero duration: done with the grant, silence, still take the gap
                            done    <= req_hot;
                            tone_en <= 1'b0;
                            state   <= GAP;
                        end else begin
                            tone_en <= 1'b1;
                            state   <= PLAY;
                        end
                    end
                end
                PLAY: begin
                    pre <= tick ? '0 : pre + PW'(1);
                    if (tick) rem <= rem - 12'd1;
                    // Expiry wins over withdrawal/preemption in the same cycle
                    if (tick && rem == 12'd1) begin
                        done    <= grant;
                        grant   <= '0;
                        tone_en <= 1'b0;
                        pre     <= '0;
                        gap_cnt <= '0;
                        state   <= (GAP_MS == 0) ? IDLE : GAP;
                    end else if (PREEMPT && |(req & above)) begin
                        abort   <= grant;
                        grant   <= req_hot;
                        tone    <= sel_tone;
                        rem     <= sel_dur;
                        pre     <= '0;
                        gap_cnt <= '0;
                        if (sel_dur == 12'd0) begin
                            done    <= req_hot;
                            tone_en <= 1'b0;
                            state   <= GAP;
                        end
                    end else if (!cur_req) begin
                        abort   <= grant;
                        grant   <= '0;
                        tone_en <= 1'b0;
                        pre     <= '0;
                        gap_cnt <= '0;
                        state   <= (GAP_MS == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    grant <= '0;
                    pre   <= tick ? '0 : pre + PW'(1);
                    if (tick) gap_cnt <= gap_cnt + GW'(1);
                    if (GAP_MS == 0 || (tick && gap_cnt == GAP_LAST)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_beeper_arbiter.sv
// Randomized bench for beeper_arbiter against a timestamp-based reference model.
module tb_beeper_arbiter;

    localparam int unsigned T = 10;
    localparam int unsigned G = 2;
    localparam int          N_CYCLES = 4000;

`ifdef BEEPER_ARB_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [4:0]  tn [3];
    logic [11:0] du [3];
    logic [2:0]  grant, done, abort;
    logic [4:0]  tone;
    logic        tone_en, busy;

    beeper_arbiter #(.TICK_DIV(T), .GAP_MS(G)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .tone0(tn[0]), .tone1(tn[1]), .tone2(tn[2]),
        .dur0(du[0]), .dur1(du[1]), .dur2(du[2]),
        .grant(grant), .done(done), .abort(abort),
        .tone(tone), .tone_en(tone_en), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: grants tracked as timestamps of edges
    int          t, t_end, t_free, g;
    bit          playing;
    logic [2:0]  e_grant, e_done, e_abort;
    logic [4:0]  e_tone;

    function automatic int highest(input logic [2:0] r);
        if (r[2]) return 2;
        if (r[1]) return 1;
        if (r[0]) return 0;
        return -1;
    endfunction

    task automatic model_reset();
        playing = 1'b0;
        e_grant = '0; e_done = '0; e_abort = '0; e_tone = '0;
        t_free  = t;
    endtask

    task automatic launch(input int i);
        e_tone  = tn[i];
        e_grant = 3'(1 << i);
        g       = i;
        if (du[i] == 12'd0) begin
            e_done[i] = 1'b1;
            playing   = 1'b0;
            t_free    = t + 1 + ((G * T > 0) ? G * T : 1);
        end else begin
            playing = 1'b1;
            t_end   = t + int'(du[i]) * T;
        end
    endtask

    task automatic finish_grant();
        playing = 1'b0;
        e_grant = '0;
        t_free  = t + G * T + 1;
    endtask

    task automatic model_step();
        t++;
        e_done  = '0;
        e_abort = '0;
        if (!playing) e_grant = '0;
        if (playing) begin
            if (t == t_end) begin
                e_done[g] = 1'b1;
                finish_grant();
            end else if (PRE && highest(req) > g) begin
                e_abort[g] = 1'b1;
                launch(highest(req));
            end else if (!req[g]) begin
                e_abort[g] = 1'b1;
                finish_grant();
            end
        end else if (t >= t_free && req != 3'b000) begin
            launch(highest(req));
        end
    endtask

    task automatic compare_all();
        check("grant",   32'(grant),   32'(e_grant));
        check("done",    32'(done),    32'(e_done));
        check("abort",   32'(abort),   32'(e_abort));
        check("tone",    32'(tone),    32'(e_tone));
        check("tone_en", 32'(tone_en), 32'(playing));
        check("busy",    32'(busy),    32'(playing || (t < t_free - 1)));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_grant"},   32'(grant),   32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_abort"},   32'(abort),   32'd0);
        check({tag, "_tone"},    32'(tone),    32'd0);
        check({tag, "_tone_en"}, 32'(tone_en), 32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
    endtask

    // Requesters: release on done/abort, occasionally withdraw, otherwise raise randomly
    task automatic drive_stimulus();
        for (int i = 0; i < 3; i++) begin
            if (e_done[i] || e_abort[i]) req[i] = 1'b0;
            else if (req[i]) begin
                if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 5) == 0) req[i] = 1'b1;
            tn[i] = 5'($urandom);
            du[i] = 12'($urandom_range(0, 4));
        end
    endtask

    bit did_rst = 1'b0;

    initial begin
        rst_n = 1'b0;
        req   = '0;
        for (int i = 0; i < 3; i++) begin
            tn[i] = '0;
            du[i] = '0;
        end
        t = 0;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < N_CYCLES; c++) begin
            @(posedge clk);
            model_step();
            #1;
            compare_all();
            drive_stimulus();
            if (!did_rst && c > N_CYCLES / 2 && playing && t_end - t > 5) begin
                did_rst = 1'b1;
                #2;
                rst_n = 1'b0;
                #1;
                check_zero("async_rst");
                repeat (2) @(posedge clk);
                #1;
                check_zero("rst_hold");
                req = '0;
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
            end
        end

        check("rst_exercised", 32'(did_rst), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
